// File: rtl/qos_pkg.sv
// Shared definitions for the QoS egress datapath: default widths, the
// destination field geometry and the routing FSM state type.
package qos_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 5;

  // Destination field occupies the DEST_W most significant bits of a word.
  localparam int DEST_W = 2;
  localparam int N_DEST = 4;

  typedef enum logic [1:0] {
    VACIO    = 2'd0,
    ENVIANDO = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  // One-hot select for a destination index.
  function automatic logic [N_DEST-1:0] onehot_dest(input logic [DEST_W-1:0] d);
    return N_DEST'(1) << d;
  endfunction

endpackage

// File: rtl/contador_entregas.sv
// Delivered-word counter: wraps modulo 2^CNT_W, increments when en is high.
module contador_entregas #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cuenta
);

  // Count one delivered word per enabled edge; natural overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (en) begin
      cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/conector_salida_fifos.sv
// Egress routing stage: drains the principal FIFO through a one-entry holding
// register and pushes each word into the destination FIFO named by its top
// bits, stalling (head-of-line) while that destination reports almost-full.
module conector_salida_fifos
  import qos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              EMPTYFP,
  input  logic [DATA_W-1:0] DATOFP,
  input  logic [3:0]        PAUSA,
  output logic              POPFP,
  output logic [3:0]        PUSHff,
  output logic [DATA_W-1:0] DATO_OUT,
  output logic [CNT_W-1:0]  CONT0,
  output logic [CNT_W-1:0]  CONT1,
  output logic [CNT_W-1:0]  CONT2,
  output logic [CNT_W-1:0]  CONT3,
  output logic              IDLE
);

  estado_t           estado, estado_sig;
  logic [DATA_W-1:0] hold_dato;
  logic              hold_valid;
  logic              drain;
  logic [DEST_W-1:0] dest;
  logic [DEST_W-1:0] dest_in;
  logic [CNT_W-1:0]  cuenta [N_DEST];

  // The holding register is occupied in every state except VACIO.
  assign hold_valid = (estado != VACIO);
  assign dest       = hold_dato[DATA_W-1 -: DEST_W];
  assign dest_in    = DATOFP[DATA_W-1 -: DEST_W];

  // Only the pause bit of the held word's destination matters.
  assign drain    = hold_valid & ~PAUSA[dest];
  assign PUSHff   = drain ? onehot_dest(dest) : '0;
  // Gated by RESET so no pop is requested while the stage is held in reset.
  assign POPFP    = RESET & ~EMPTYFP & (~hold_valid | drain);
  assign DATO_OUT = hold_dato;
  assign IDLE     = ~hold_valid & EMPTYFP;

  // Next FSM state: a pop refills the register, a lone drain empties it,
  // otherwise the held word tracks its destination's pause bit.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    estado_sig = estado;
    if (POPFP) begin
      estado_sig = PAUSA[dest_in] ? ESPERA : ENVIANDO;
    end else if (drain) begin
      estado_sig = VACIO;
    end else if (hold_valid) begin
      estado_sig = PAUSA[dest] ? ESPERA : ENVIANDO;
    end
  end

  // State and holding register; a word held at reset is discarded.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      estado    <= VACIO;
      hold_dato <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      estado <= estado_sig;
      if (POPFP) begin
        hold_dato <= DATOFP;
      end
    end
  end

  // One delivered-word counter per destination FIFO.
  for (genvar i = 0; i < N_DEST; i++) begin : g_cont
    contador_entregas #(.CNT_W(CNT_W)) u_cont (
      .clk    (CLOCK),
      .rst_n  (RESET),
      .en     (PUSHff[i]),
      .cuenta (cuenta[i])
    );
  end

  assign CONT0 = cuenta[0];
  assign CONT1 = cuenta[1];
  assign CONT2 = cuenta[2];
  assign CONT3 = cuenta[3];

endmodule

// File: tb/tb_conector_salida_fifos.sv
// Self-checking bench for conector_salida_fifos: a source queue models the
// principal FIFO, a scoreboard queue holds words popped but not yet pushed.
module tb_conector_salida_fifos;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 5;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              EMPTYFP;
  logic [DATA_W-1:0] DATOFP;
  logic [3:0]        PAUSA;
  logic              POPFP;
  logic [3:0]        PUSHff;
  logic [DATA_W-1:0] DATO_OUT;
  logic [CNT_W-1:0]  CONT0, CONT1, CONT2, CONT3;
  logic              IDLE;

  conector_salida_fifos #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .EMPTYFP  (EMPTYFP),
    .DATOFP   (DATOFP),
    .PAUSA    (PAUSA),
    .POPFP    (POPFP),
    .PUSHff   (PUSHff),
    .DATO_OUT (DATO_OUT),
    .CONT0    (CONT0),
    .CONT1    (CONT1),
    .CONT2    (CONT2),
    .CONT3    (CONT3),
    .IDLE     (IDLE)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] sb_q[$];
  logic [CNT_W-1:0]  exp_cnt [4];
  logic              force_empty = 1'b0;

  task automatic refresh_src();
    EMPTYFP = force_empty || (src_q.size() == 0);
    DATOFP  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // One clock cycle: sample at the falling edge against the scoreboard model,
  // advance the model, then update the source after the rising edge.
  task automatic cycle(output logic [3:0] push_seen, output logic pop_seen);
    logic [3:0]        exp_push;
    logic              exp_pop;
    logic [DATA_W-1:0] head;
    @(negedge CLOCK);
    exp_push = 4'b0000;
    head     = '0;
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      if (!PAUSA[head[DATA_W-1 -: 2]]) exp_push = 4'b0001 << head[DATA_W-1 -: 2];
    end
    exp_pop = RESET && !EMPTYFP && ((sb_q.size() == 0) || (exp_push != 4'b0000));
    n_checks++;
    if (PUSHff !== exp_push) begin
      n_fail++;
      $display("FAIL push_vector t=%0t: got %b expected %b", $time, PUSHff, exp_push);
    end
    n_checks++;
    if (POPFP !== exp_pop) begin
      n_fail++;
      $display("FAIL pop_request t=%0t: got %b expected %b", $time, POPFP, exp_pop);
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      if (DATO_OUT !== head) begin
        n_fail++;
        $display("FAIL dato_out t=%0t: got %b expected %b", $time, DATO_OUT, head);
      end
    end
    push_seen = PUSHff;
    pop_seen  = POPFP;
    for (int i = 0; i < 4; i++) if (exp_push[i]) exp_cnt[i] = exp_cnt[i] + 1'b1;
    if (exp_push != 4'b0000) void'(sb_q.pop_front());
    if (exp_pop && src_q.size() != 0) sb_q.push_back(src_q.pop_front());
    @(posedge CLOCK);
    #1;
    refresh_src();
  endtask

  task automatic drain_all();
    logic [3:0] p;
    logic       q;
    int         budget;
    budget = 200;
    while ((src_q.size() != 0 || sb_q.size() != 0) && budget > 0) begin
      cycle(p, q);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", src_q.size() + sb_q.size());
    end
  endtask

  task automatic check_counters(input string name);
    logic [CNT_W-1:0] got [4];
    got[0] = CONT0; got[1] = CONT1; got[2] = CONT2; got[3] = CONT3;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL %s_cont%0d: got %0d expected %0d", name, i, got[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    src_q.delete();
    sb_q.delete();
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    refresh_src();
  endtask

  task automatic test_reset();
    PAUSA   = 4'b0000;
    RESET   = 1'b1;
    #1;
    RESET   = 1'b0;
    EMPTYFP = 1'b0;
    DATOFP  = 6'b10_1010;
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
    #2;
    n_checks++;
    if (POPFP !== 1'b0) begin n_fail++; $display("FAIL reset_popfp: got %b expected 0", POPFP); end
    n_checks++;
    if (PUSHff !== 4'b0000) begin n_fail++; $display("FAIL reset_pushff: got %b expected 0000", PUSHff); end
    n_checks++;
    if (DATO_OUT !== 6'b000000) begin n_fail++; $display("FAIL reset_dato_out: got %b expected 000000", DATO_OUT); end
    n_checks++;
    if (IDLE !== 1'b0) begin n_fail++; $display("FAIL reset_idle_nonempty: got %b expected 0", IDLE); end
    check_counters("reset");
    EMPTYFP = 1'b1;
    #1;
    n_checks++;
    if (IDLE !== 1'b1) begin n_fail++; $display("FAIL reset_idle_empty: got %b expected 1", IDLE); end
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    refresh_src();
  endtask

  task automatic test_stream();
    logic [3:0] exp_seq [5];
    logic [3:0] p;
    logic       q;
    exp_seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    PAUSA = 4'b0000;
    src_q = '{6'b00_0011, 6'b01_0101, 6'b10_0110, 6'b11_1001};
    refresh_src();
    for (int i = 0; i < 5; i++) begin
      cycle(p, q);
      n_checks++;
      if (p !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL stream_push%0d: got %b expected %b", i, p, exp_seq[i]);
      end
    end
    n_checks++;
    if ({CONT3, CONT2, CONT1, CONT0} !== {5'd1, 5'd1, 5'd1, 5'd1}) begin
      n_fail++;
      $display("FAIL stream_counters: got %0d %0d %0d %0d expected 1 1 1 1", CONT0, CONT1, CONT2, CONT3);
    end
    drain_all();
  endtask

  task automatic test_pause_hold();
    logic [3:0] p;
    logic       q;
    PAUSA = 4'b0100;
    src_q = '{6'b10_1111, 6'b00_0001};
    refresh_src();
    cycle(p, q);
    for (int i = 0; i < 5; i++) begin
      cycle(p, q);
      n_checks++;
      if (p !== 4'b0000 || q !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_blocked%0d: got push %b pop %b expected push 0000 pop 0", i, p, q);
      end
      n_checks++;
      if (DATO_OUT !== 6'b10_1111) begin
        n_fail++;
        $display("FAIL pause_dato_stable%0d: got %b expected 101111", i, DATO_OUT);
      end
    end
    PAUSA = 4'b0000;
    cycle(p, q);
    n_checks++;
    if (p !== 4'b0100 || q !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_release: got push %b pop %b expected push 0100 pop 1", p, q);
    end
    drain_all();
    check_counters("pause");
  endtask

  task automatic test_irrelevant_pause();
    logic [3:0] p;
    logic       q;
    PAUSA = 4'b1011;
    for (int i = 0; i < 8; i++) src_q.push_back(6'b10_0000 | 6'(i));
    refresh_src();
    cycle(p, q);
    for (int i = 0; i < 8; i++) begin
      cycle(p, q);
      n_checks++;
      if (p !== 4'b0100 || q !== (i < 7)) begin
        n_fail++;
        $display("FAIL irrelevant_rate%0d: got push %b pop %b expected push 0100 pop %b", i, p, q, (i < 7));
      end
    end
    check_counters("irrelevant");
    PAUSA = 4'b0000;
  endtask

  task automatic test_empty_boundary();
    logic [3:0] p;
    logic       q;
    logic       exp_idle;
    PAUSA = 4'b0000;
    src_q = '{6'b00_0111, 6'b01_0001, 6'b11_0010, 6'b10_1100, 6'b00_1000, 6'b11_1111};
    for (int i = 0; i < 14; i++) begin
      force_empty = i[0];
      refresh_src();
      #1;
      exp_idle = (sb_q.size() == 0) && EMPTYFP;
      n_checks++;
      if (IDLE !== exp_idle) begin
        n_fail++;
        $display("FAIL empty_idle%0d: got %b expected %b", i, IDLE, exp_idle);
      end
      if (EMPTYFP) begin
        n_checks++;
        if (POPFP !== 1'b0) begin
          n_fail++;
          $display("FAIL empty_pop_while_empty%0d: got %b expected 0", i, POPFP);
        end
      end
      cycle(p, q);
    end
    force_empty = 1'b0;
    refresh_src();
    drain_all();
    check_counters("empty");
  endtask

  task automatic test_wrap();
    apply_reset();
    PAUSA = 4'b0000;
    for (int i = 0; i < 33; i++) src_q.push_back(6'(i % 16));
    refresh_src();
    drain_all();
    n_checks++;
    if (CONT0 !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_cont0: got %0d expected 1", CONT0);
    end
    check_counters("wrap");
  endtask

  task automatic test_midreset();
    logic [3:0] p;
    logic       q;
    PAUSA = 4'b0010;
    src_q = '{6'b01_1010};
    refresh_src();
    repeat (3) cycle(p, q);
    #3;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (PUSHff !== 4'b0000 || POPFP !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_handshake: got push %b pop %b expected push 0000 pop 0", PUSHff, POPFP);
    end
    n_checks++;
    if (DATO_OUT !== 6'b000000) begin
      n_fail++;
      $display("FAIL midreset_dato_out: got %b expected 000000", DATO_OUT);
    end
    n_checks++;
    if (IDLE !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_idle: got %b expected 1", IDLE);
    end
    sb_q.delete();
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
    check_counters("midreset");
    @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    PAUSA = 4'b0000;
    refresh_src();
    for (int i = 0; i < 4; i++) begin
      cycle(p, q);
      n_checks++;
      if (p !== 4'b0000) begin
        n_fail++;
        $display("FAIL midreset_no_push%0d: got %b expected 0000", i, p);
      end
    end
    check_counters("after_midreset");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_stream();
    test_pause_hold();
    test_irrelevant_pause();
    test_empty_boundary();
    test_wrap();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
